uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 217, clk cycles per bit; legal range >= 8.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 = even, 1 = odd; used only with UART_RX_PARITY_EN.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-008 SHALL have port data_out  output  DATA_BITS  FIFO head byte, LSB = first bit received.
REQ-009 SHALL have port data_valid  output  1  FIFO non-empty; data_out valid.
REQ-010 SHALL have port data_ready  input  1  consumer pop; pops when data_valid && data_ready at a clk edge.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port parity_err  output  1  one-cycle pulse: received parity mismatch.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse: good frame dropped because FIFO full.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: synchronized rx low -> START, bit counter loaded with CLK_DIV/2-1.
REQ-018 START: counter at 0, rx low -> DATA with counter CLK_DIV-1; rx high -> IDLE (glitch rejected, no pulse).
REQ-019 DATA: sample once per counter expiry, LSB first, DATA_BITS samples, then PARITY (macro on) or STOP.
REQ-020 PARITY: sample one bit; error if XOR(data, parity bit) != PARITY_ODD.
REQ-021 STOP: sample at mid-bit, then return to IDLE in the next cycle; the remaining half stop bit is not waited out.
REQ-022 STOP sample low: pulse frame_err, discard frame, no FIFO write, no parity_err pulse.
REQ-023 STOP sample high with parity error: pulse parity_err, discard frame.
REQ-024 STOP sample high, no error: write byte to FIFO in the same cycle.
REQ-025 Good frame with FIFO full and no pop that cycle: drop byte, pulse overrun, leave FIFO contents unchanged.
REQ-026 Write and pop in the same cycle, including when the FIFO is full: both take effect; fifo_count unchanged.
REQ-027 FIFO SHALL be first-word-fall-through; data_out = head entry and is held stable while data_valid && !data_ready.
REQ-028 Pop while empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-029 Error pulses SHALL be mutually exclusive and last exactly one clk cycle.

Reset
REQ-030 Reset asserted SHALL immediately force FSM to IDLE, counters 0, FIFO empty, synchronizer flops high.
REQ-031 Reset SHALL force data_valid, frame_err, parity_err, overrun, fifo_count to 0 and data_out to 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; nothing is written; next falling edge after release starts a new frame.

Configuration
REQ-033 Macro UART_RX_PARITY_EN defined: frame = start + DATA_BITS + parity + stop; PARITY state active.
REQ-034 Macro UART_RX_PARITY_EN undefined: no PARITY state; frame = start + DATA_BITS + stop; parity_err tied 0.

Verification
REQ-035 CLK_DIV=16, DATA_BITS=8, macro off: send 0xA5 -> data_valid high with data_out=0xA5 after the stop mid-sample; fifo_count=1.
REQ-036 Send 0x3C with a stop bit low -> single frame_err pulse; fifo_count stays 0.
REQ-037 Macro on, PARITY_ODD=0: send 0x07 with parity bit 0 -> parity_err pulse, nothing written; send 0x07 with parity bit 1 -> accepted.
REQ-038 FIFO_DEPTH=4, data_ready=0: send 0x01..0x05 -> fifo_count=4, overrun pulse on 0x05; pops return 0x01..0x04 in order.
REQ-039 rx low pulse of 4 cycles while idle -> no write, no error pulses, FSM back in IDLE.
REQ-040 Assert reset in the middle of bit 3 of 0x55, release, send 0x99 -> only 0x99 appears at data_out.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling feeding a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN to expect a parity bit (sense PARITY_ODD) between data and stop.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 217,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [1:0]            sync;
    logic                  rx_s;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  tick;
    logic                  last_bit;
    logic                  load_half;
    logic                  load_full;
    logic                  shift_en;
    logic                  stop_fire;
    logic                  parity_bad;
    logic                  good_frame;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];

    // Synchronizer resets high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], rx};
    end
    assign rx_s = sync[1];

    assign tick     = (cnt == '0);
    assign last_bit = (bit_idx == BW'(DATA_BITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (!rx_s) next_state = START;
            START:  if (tick) next_state = rx_s ? IDLE : DATA;
            DATA: begin
                if (tick && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) next_state = STOP;
`endif
            STOP:   if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        stop_fire = 1'b0;
        case (state)
            IDLE:  load_half = !rx_s;
            START: load_full = tick && !rx_s;
            DATA: begin
                shift_en  = tick;
                load_full = tick;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: load_full = tick;
`endif
            STOP:  stop_fire = tick;
            default: ;
        endcase
    end

    // Counter idles at zero; every sample point is the cycle it reaches zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (load_half)      cnt <= CW'(CLK_DIV / 2 - 1);
            else if (load_full) cnt <= CW'(CLK_DIV - 1);
            else if (!tick)     cnt <= cnt - 1'b1;
            if (shift_en) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          par_bit <= 1'b0;
        else if (state == PARITY && tick)   par_bit <= rx_s;
    end

    assign parity_bad = ((^shreg) ^ par_bit) != (PARITY_ODD != 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= stop_fire && rx_s && parity_bad;
    end
`else
    assign parity_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign good_frame = stop_fire && rx_s && !parity_bad;
    assign full       = (fifo_count == (PW + 1)'(FIFO_DEPTH));
    assign pop        = data_valid && data_ready;
    assign push       = good_frame && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_fire && !rx_s;
            overrun   <= good_frame && full && !pop;
        end
    end

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    assign data_valid = (fifo_count != '0);
    assign data_out   = data_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame-level model with a per-cycle compare process.
// Parity scenarios run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;
    localparam int CLK_DIV    = 16;
    localparam int DATA_BITS  = 8;
    localparam int PARITY_ODD = 0;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    // Edge on which a frame's outcome becomes visible, counted from the edge before rx falls.
    localparam int LAT = 3 + CLK_DIV / 2 + CLK_DIV * (DATA_BITS + 1 + PAR_EN);

    localparam int K_GOOD   = 0;
    localparam int K_FRAME  = 1;
    localparam int K_PARITY = 2;

    typedef struct {
        int         edge_no;
        int         kind;
        logic [7:0] data;
    } event_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int         checks;
    int         errors;
    int         cyc;
    int         fe_seen;
    int         pe_seen;
    int         ov_seen;
    logic [7:0] model_q[$];
    event_t     pending[$];
    event_t     ev;
    logic       pop_now;
    logic       exp_fe;
    logic       exp_pe;
    logic       exp_ov;
    logic [7:0] exp_head;

    uart_rx_fifo #(
        .CLK_DIV(CLK_DIV),
        .DATA_BITS(DATA_BITS),
        .PARITY_ODD(PARITY_ODD),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .data_out(data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overrun(overrun),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    function automatic logic good_par(input logic [7:0] v);
        return (^v) ^ logic'(PARITY_ODD);
    endfunction

    // Sends one frame starting at a negedge and records the outcome the frame must produce.
    task automatic applyStimulus(input logic [7:0] value, input logic par_bit, input logic stop_bit);
        event_t e;
        e.edge_no = cyc + LAT;
        e.data    = value;
        if (!stop_bit)                                             e.kind = K_FRAME;
        else if (PAR_EN != 0 && (((^value) ^ par_bit) != logic'(PARITY_ODD))) e.kind = K_PARITY;
        else                                                       e.kind = K_GOOD;
        pending.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(value[i]);
        if (PAR_EN != 0) send_bit(par_bit);
        send_bit(stop_bit);
        send_bit(1'b1);
    endtask

    task automatic send_good(input logic [7:0] value);
        applyStimulus(value, good_par(value), 1'b1);
    endtask

    // Model update on each active edge, then compare the settled DUT outputs.
    always @(posedge clk) begin
        cyc++;
        exp_fe = 1'b0;
        exp_pe = 1'b0;
        exp_ov = 1'b0;
        if (reset) begin
            model_q.delete();
            pending.delete();
        end else begin
            pop_now = (model_q.size() != 0) && data_ready;
            if (pop_now) void'(model_q.pop_front());
            if (pending.size() != 0 && pending[0].edge_no == cyc) begin
                ev = pending.pop_front();
                if (ev.kind == K_FRAME)                 exp_fe = 1'b1;
                else if (ev.kind == K_PARITY)           exp_pe = 1'b1;
                else if (model_q.size() == FIFO_DEPTH)  exp_ov = 1'b1;
                else                                    model_q.push_back(ev.data);
            end
        end
        #1;
        exp_head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        checkOutput("cyc_valid", 32'(data_valid), 32'(model_q.size() != 0));
        checkOutput("cyc_count", 32'(fifo_count), 32'(model_q.size()));
        checkOutput("cyc_data_out", 32'(data_out), 32'(exp_head));
        checkOutput("cyc_frame_err", 32'(frame_err), 32'(exp_fe));
        checkOutput("cyc_parity_err", 32'(parity_err), 32'(exp_pe));
        checkOutput("cyc_overrun", 32'(overrun), 32'(exp_ov));
        fe_seen += int'(frame_err);
        pe_seen += int'(parity_err);
        ov_seen += int'(overrun);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        logic [7:0] v55;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        fe_seen = 0;
        pe_seen = 0;
        ov_seen = 0;
        reset      = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_valid", 32'(data_valid), 32'd0);
        checkOutput("reset_data_out", 32'(data_out), 32'd0);
        checkOutput("reset_pulses", 32'({frame_err, parity_err, overrun}), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] single good frame 0xA5");
        send_good(8'hA5);
        checkOutput("a5_valid", 32'(data_valid), 32'd1);
        checkOutput("a5_data", 32'(data_out), 32'hA5);
        checkOutput("a5_count", 32'(fifo_count), 32'd1);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        checkOutput("a5_popped", 32'(fifo_count), 32'd0);

        $display("[TB] stop bit low on 0x3C");
        applyStimulus(8'h3C, good_par(8'h3C), 1'b0);
        checkOutput("fe_pulses", 32'(fe_seen), 32'd1);
        checkOutput("fe_count", 32'(fifo_count), 32'd0);

        $display("[TB] 4-cycle glitch while idle");
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        checkOutput("glitch_count", 32'(fifo_count), 32'd0);
        checkOutput("glitch_pulses", 32'(fe_seen + pe_seen + ov_seen), 32'd1);
        send_good(8'h5A);
        checkOutput("after_glitch_data", 32'(data_out), 32'h5A);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity check on 0x07");
        applyStimulus(8'h07, 1'b0, 1'b1);
        checkOutput("par_pulses", 32'(pe_seen), 32'd1);
        checkOutput("par_count", 32'(fifo_count), 32'd0);
        applyStimulus(8'h07, 1'b1, 1'b1);
        checkOutput("par_ok_data", 32'(data_out), 32'h07);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
`endif

        $display("[TB] overrun with 0x01..0x05");
        for (int i = 1; i <= 5; i++) send_good(8'(i));
        checkOutput("ovr_count", 32'(fifo_count), 32'd4);
        checkOutput("ovr_pulses", 32'(ov_seen), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("ovr_pop_data", 32'(data_out), 32'(i));
            data_ready = 1'b1;
            @(negedge clk);
        end
        data_ready = 1'b0;
        checkOutput("ovr_drained", 32'(fifo_count), 32'd0);

        $display("[TB] pop while empty");
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        data_ready = 1'b0;
        checkOutput("empty_pop_count", 32'(fifo_count), 32'd0);

        $display("[TB] write and pop together while full");
        for (int i = 0; i < 4; i++) send_good(8'h10 + 8'(i));
        t = cyc + LAT;
        fork
            send_good(8'h14);
            begin
                while (cyc < t - 1) @(negedge clk);
                data_ready = 1'b1;
                @(negedge clk);
                data_ready = 1'b0;
            end
        join
        checkOutput("full_rw_count", 32'(fifo_count), 32'd4);
        checkOutput("full_rw_overrun", 32'(ov_seen), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("full_rw_data", 32'(data_out), 32'h10 + 32'(i));
            data_ready = 1'b1;
            @(negedge clk);
        end
        data_ready = 1'b0;

        $display("[TB] reset in the middle of 0x55");
        v55 = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(v55[i]);
        rx = v55[3];
        repeat (CLK_DIV / 2) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("midreset_count", 32'(fifo_count), 32'd0);
        reset = 1'b0;
        repeat (CLK_DIV * 12) @(negedge clk);
        checkOutput("midreset_idle_count", 32'(fifo_count), 32'd0);
        send_good(8'h99);
        checkOutput("midreset_data", 32'(data_out), 32'h99);
        checkOutput("midreset_after_count", 32'(fifo_count), 32'd1);
        checkOutput("total_frame_errs", 32'(fe_seen), 32'd1);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
